// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-port arbiter in front of the 1024x64 RAM macro.
package ram_arb_pkg;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;
  localparam int unsigned NB = DW / 8;

  typedef logic [0:0] port_t;

  typedef enum logic [1:0] {
    EMPTY,
    INFLIGHT,
    FULL
  } slot_state_t;

  typedef struct packed {
    logic [NB-1:0] we;
    logic [AW-1:0] a;
    logic [DW-1:0] di;
  } ram_req_t;

endpackage

// File: rtl/ram_arb_rsp_slot.sv
// Per-port read response slot: tracks one outstanding read and holds its data until consumed.
module ram_arb_rsp_slot
  import ram_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          grant_rd,
  input  logic          rready,
  input  logic [DW-1:0] ram_do,
  output logic          read_eligible,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);

  slot_state_t state_q, state_d;

  // State register and read-data capture one cycle after the macro read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INFLIGHT) rdata <= ram_do;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:    if (grant_rd) state_d = INFLIGHT;
      INFLIGHT: state_d = FULL;
      FULL:     if (rready) state_d = grant_rd ? INFLIGHT : EMPTY;
      default:  state_d = EMPTY;
    endcase
  end

  // A FULL slot may take a new read in the same cycle its data is consumed
  assign read_eligible = (state_q == EMPTY) || ((state_q == FULL) && rready);
  assign rvalid        = (state_q == FULL);

endmodule

// File: rtl/ram_1024x64_arbiter.sv
// Round-robin arbiter and sequencer giving two requesters access to one single-port RAM macro.
module ram_1024x64_arbiter
  import ram_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic [NB-1:0] p0_we,
  input  logic [AW-1:0] p0_a,
  input  logic [DW-1:0] p0_di,
  output logic          p0_rvalid,
  input  logic          p0_rready,
  output logic [DW-1:0] p0_do,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic [NB-1:0] p1_we,
  input  logic [AW-1:0] p1_a,
  input  logic [DW-1:0] p1_di,
  output logic          p1_rvalid,
  input  logic          p1_rready,
  output logic [DW-1:0] p1_do,
  output logic          ram_en,
  output logic [NB-1:0] ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do
);

  ram_req_t req0, req1, win_req;
  port_t    last_q, win;
  logic     rd_elig0, rd_elig1, elig0, elig1, gnt_any;
  logic     grant_rd0, grant_rd1;

  assign req0 = '{we: p0_we, a: p0_a, di: p0_di};
  assign req1 = '{we: p1_we, a: p1_a, di: p1_di};

  // Writes are always eligible; reads only when the response slot can take them
  assign elig0 = rst_n & p0_valid & ((|p0_we) | rd_elig0);
  assign elig1 = rst_n & p1_valid & ((|p1_we) | rd_elig1);

  always_comb begin
    gnt_any = elig0 | elig1;
    win     = 1'b0;
    if (elig0 && elig1) win = ~last_q;
    else if (elig1)     win = 1'b1;
  end

  assign p0_ready  = gnt_any & (win == 1'b0);
  assign p1_ready  = gnt_any & (win == 1'b1);
  assign grant_rd0 = p0_ready & ~(|p0_we);
  assign grant_rd1 = p1_ready & ~(|p1_we);

  assign win_req = win[0] ? req1 : req0;
  assign ram_en  = gnt_any;
  assign ram_we  = gnt_any ? win_req.we : '0;
  assign ram_a   = win_req.a;
  assign ram_di  = win_req.di;

  // Last-granted port; reset to 1 so port 0 wins the first conflict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_q <= 1'b1;
    else if (gnt_any) last_q <= win;
  end

  ram_arb_rsp_slot u_slot0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .grant_rd     (grant_rd0),
    .rready       (p0_rready),
    .ram_do       (ram_do),
    .read_eligible(rd_elig0),
    .rvalid       (p0_rvalid),
    .rdata        (p0_do)
  );

  ram_arb_rsp_slot u_slot1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .grant_rd     (grant_rd1),
    .rready       (p1_rready),
    .ram_do       (ram_do),
    .read_eligible(rd_elig1),
    .rvalid       (p1_rvalid),
    .rdata        (p1_do)
  );

endmodule

// File: tb/tb_ram_1024x64_arbiter.sv
// Self-checking bench: behavioural RAM macro plus a transaction-level reference of grants and responses.
module tb_ram_1024x64_arbiter;
  import ram_arb_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          vld [2];
  logic [NB-1:0] we [2];
  logic [AW-1:0] a [2];
  logic [DW-1:0] di [2];
  logic          rrdy [2];
  logic          rdy [2];
  logic          rv [2];
  logic [DW-1:0] dout [2];
  logic          ram_en;
  logic [NB-1:0] ram_we;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_di, ram_do;
  logic [DW-1:0] mem [1024];

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit            m_rv [2];
  bit            m_infl [2];
  logic [DW-1:0] m_do [2];
  logic [DW-1:0] m_pend [2];
  int            m_last;
  logic [DW-1:0] ref_mem [1024];
  int            win;
  bit            g [2];
  logic          obs_rdy [2];
  logic          obs_rv [2];
  logic [DW-1:0] obs_do [2];

  always #5 clk = ~clk;

  ram_1024x64_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p0_valid (vld[0]),
    .p0_ready (rdy[0]),
    .p0_we    (we[0]),
    .p0_a     (a[0]),
    .p0_di    (di[0]),
    .p0_rvalid(rv[0]),
    .p0_rready(rrdy[0]),
    .p0_do    (dout[0]),
    .p1_valid (vld[1]),
    .p1_ready (rdy[1]),
    .p1_we    (we[1]),
    .p1_a     (a[1]),
    .p1_di    (di[1]),
    .p1_rvalid(rv[1]),
    .p1_rready(rrdy[1]),
    .p1_do    (dout[1]),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_a    (ram_a),
    .ram_di   (ram_di),
    .ram_do   (ram_do)
  );

  // Single-port byte-writable macro: read data appears the cycle after an enabled read
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == '0) ram_do <= mem[ram_a];
      else
        for (int i = 0; i < int'(NB); i++)
          if (ram_we[i]) mem[ram_a][8*i +: 8] <= ram_di[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_rv[p] = 1'b0; m_infl[p] = 1'b0; m_do[p] = '0; m_pend[p] = '0;
    end
    m_last = 1;
  endtask

  // Who should win this cycle, from the request and response-slot rules
  task automatic eval();
    bit e [2];
    for (int p = 0; p < 2; p++)
      e[p] = vld[p] && (we[p] != '0 || (!m_infl[p] && (!m_rv[p] || rrdy[p])));
    win = -1;
    if (e[0] && e[1]) win = 1 - m_last;
    else if (e[0])    win = 0;
    else if (e[1])    win = 1;
    for (int p = 0; p < 2; p++) g[p] = (win == p);
  endtask

  task automatic upd();
    bit oi [2];
    for (int p = 0; p < 2; p++) oi[p] = m_infl[p];
    for (int p = 0; p < 2; p++) begin
      if (m_rv[p] && rrdy[p]) m_rv[p] = 1'b0;
      if (oi[p]) begin m_rv[p] = 1'b1; m_do[p] = m_pend[p]; m_infl[p] = 1'b0; end
    end
    if (win >= 0) begin
      if (we[win] == '0) begin
        m_infl[win] = 1'b1;
        m_pend[win] = ref_mem[a[win]];
      end else begin
        for (int i = 0; i < int'(NB); i++)
          if (we[win][i]) ref_mem[a[win]][8*i +: 8] = di[win][8*i +: 8];
      end
      m_last = win;
    end
  endtask

  // One clock: check settled outputs mid-cycle, then advance the model at the edge
  task automatic step();
    #3;
    eval();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("ready%0d", p), 64'(rdy[p]), 64'(g[p]));
      chk($sformatf("rvalid%0d", p), 64'(rv[p]), 64'(m_rv[p]));
      chk($sformatf("do%0d", p), dout[p], m_do[p]);
      obs_rdy[p] = rdy[p]; obs_rv[p] = rv[p]; obs_do[p] = dout[p];
    end
    chk("ram_en", 64'(ram_en), 64'(win >= 0));
    if (win >= 0) begin
      chk("ram_we", 64'(ram_we), 64'(we[win]));
      chk("ram_a", 64'(ram_a), 64'(a[win]));
      chk("ram_di", ram_di, di[win]);
    end else begin
      chk("ram_we_idle", 64'(ram_we), 64'd0);
    end
    @(posedge clk);
    upd();
    #1;
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) begin
      #3;
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("rst_ready%0d", p), 64'(rdy[p]), 64'd0);
        chk($sformatf("rst_rvalid%0d", p), 64'(rv[p]), 64'd0);
        chk($sformatf("rst_do%0d", p), dout[p], 64'd0);
      end
      chk("rst_ram_en", 64'(ram_en), 64'd0);
      chk("rst_ram_we", 64'(ram_we), 64'd0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] ad);
    vld[p] = 1'b1; we[p] = '0; a[p] = ad; di[p] = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] ad, input logic [NB-1:0] w, input logic [DW-1:0] d);
    vld[p] = 1'b1; we[p] = w; a[p] = ad; di[p] = d;
  endtask

  task automatic idle(input int p);
    vld[p] = 1'b0;
  endtask

  task automatic rnd_req(input int p);
    vld[p] = ($urandom_range(0, 3) != 0);
    a[p]   = AW'($urandom_range(0, 15));
    we[p]  = ($urandom_range(0, 1) == 0) ? '0 : NB'($urandom_range(1, 255));
    di[p]  = {$urandom, $urandom};
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    ram_do = '0;
    for (int p = 0; p < 2; p++) begin
      vld[p] = 1'b0; we[p] = '0; a[p] = '0; di[p] = '0; rrdy[p] = 1'b1;
    end
    model_reset();
    #1;
    rd(0, 10'd10); rd(1, 10'd20);
    hold_reset(3);

    // First conflict after reset goes to port 0
    step();
    chk("first_grant_p0", 64'(obs_rdy[0]), 64'd1);
    chk("first_grant_p1", 64'(obs_rdy[1]), 64'd0);
    idle(0);
    step();
    chk("second_grant_p1", 64'(obs_rdy[1]), 64'd1);
    idle(1);
    repeat (3) step();

    // Write then read the top address
    wr(0, 10'h3FF, 8'hFF, 64'h0123456789ABCDEF);
    step();
    chk("wr_grant", 64'(obs_rdy[0]), 64'd1);
    rd(0, 10'h3FF);
    step();
    chk("rd_grant", 64'(obs_rdy[0]), 64'd1);
    idle(0);
    step();
    chk("rd_n1_rvalid", 64'(obs_rv[0]), 64'd0);
    step();
    chk("rd_n2_rvalid", 64'(obs_rv[0]), 64'd1);
    chk("rd_n2_data", obs_do[0], 64'h0123456789ABCDEF);

    // Byte-masked write over a zero word
    wr(1, 10'h155, 8'h0F, '1);
    step();
    rd(1, 10'h155);
    step();
    idle(1);
    step();
    step();
    chk("bytemask_rvalid", 64'(obs_rv[1]), 64'd1);
    chk("bytemask_data", obs_do[1], 64'h00000000FFFFFFFF);

    // Both ports writing every cycle must alternate
    wr(0, AW'($urandom_range(16, 31)), 8'hFF, {$urandom, $urandom});
    wr(1, AW'($urandom_range(16, 31)), 8'hFF, {$urandom, $urandom});
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("alt_p0_%0d", k), 64'(obs_rdy[0]), 64'((k % 2) == 0));
      chk($sformatf("alt_p1_%0d", k), 64'(obs_rdy[1]), 64'((k % 2) == 1));
      for (int p = 0; p < 2; p++)
        if (g[p]) wr(p, AW'($urandom_range(16, 31)), NB'($urandom_range(1, 255)), {$urandom, $urandom});
    end
    rd(0, AW'($urandom_range(16, 31)));
    rd(1, AW'($urandom_range(16, 31)));
    repeat (8) begin
      step();
      for (int p = 0; p < 2; p++)
        if (g[p]) rd(p, AW'($urandom_range(16, 31)));
    end
    idle(0); idle(1);
    repeat (3) step();

    // Backpressure on a full slot
    rrdy[0] = 1'b0;
    rd(0, 10'h3FF);
    step();
    chk("bp_first_grant", 64'(obs_rdy[0]), 64'd1);
    idle(0);
    step();
    step();
    rd(0, 10'h001);
    step();
    chk("bp_rd_blocked", 64'(obs_rdy[0]), 64'd0);
    chk("bp_rvalid", 64'(obs_rv[0]), 64'd1);
    chk("bp_do", obs_do[0], 64'h0123456789ABCDEF);
    wr(0, 10'h007, 8'hFF, 64'hCAFEF00DDEADBEEF);
    step();
    chk("bp_wr_granted", 64'(obs_rdy[0]), 64'd1);
    chk("bp_do_hold", obs_do[0], 64'h0123456789ABCDEF);
    rd(0, 10'h007);
    rrdy[0] = 1'b1;
    step();
    chk("bp_release_grant", 64'(obs_rdy[0]), 64'd1);
    idle(0);
    step();
    chk("bp_gap", 64'(obs_rv[0]), 64'd0);
    step();
    chk("bp_new_rvalid", 64'(obs_rv[0]), 64'd1);
    chk("bp_new_data", obs_do[0], 64'hCAFEF00DDEADBEEF);
    step();

    // Reset the cycle after a read grant: response must be discarded
    rd(0, 10'h3FF);
    step();
    chk("mid_rd_grant", 64'(obs_rdy[0]), 64'd1);
    idle(0);
    hold_reset(2);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("post_reset_rvalid_%0d", k), 64'(obs_rv[0]), 64'd0);
    end

    // Randomized traffic with protocol-respecting request holding
    rnd_req(0); rnd_req(1);
    repeat (400) begin
      for (int p = 0; p < 2; p++) rrdy[p] = 1'($urandom_range(0, 1));
      step();
      for (int p = 0; p < 2; p++)
        if (!vld[p] || g[p]) rnd_req(p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
